// File: rtl/s1488_bist_ctrl.sv
// s1488_bist_ctrl: LFSR-driven BIST controller with MISR signature check for one s1488 output slice
//   CK        in   clock, rising edge
//   CLR       in   asynchronous active-low reset
//   start     in   level; begins a run from IDLE or DONE
//   golden    in   [15:0] expected signature, compared in DONE
//   cut_resp  in   single-bit slice response
//   pat_vec   out  [13:0] slice stimulus; [12:0] = v12..v0, [13] = slice CLR
//   busy      out  high in RUN and DRAIN
//   done      out  high in DONE
//   signature out  [15:0] MISR contents
//   pass      out  high in DONE when signature == golden
// Optional macro S1488_BIST_HOLD_CLR_EN: pins pat_vec[13] high so the slice reset stays inactive.
module s1488_bist_ctrl #(
  parameter int unsigned PAT_COUNT = 1024,
  parameter logic [13:0] SEED = 14'h0001
) (
  input  logic        CK,
  input  logic        CLR,
  input  logic        start,
  input  logic [15:0] golden,
  input  logic        cut_resp,
  output logic [13:0] pat_vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        pass
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // An all-zero seed would lock the LFSR.
  localparam logic [13:0] SEED_EFF = (SEED == 14'h0) ? 14'h0001 : SEED;
  localparam logic [15:0] PC = 16'(PAT_COUNT);
  state_t state_q, state_d;
  logic [13:0] lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d, cnt_q, cnt_d, fold;
  logic resp_q, resp_d, vld_q, vld_d, fb;
  assign fb = lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[1];
  assign fold = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'hA011 : 16'h0) ^ {15'b0, resp_q};
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      misr_q  <= '0;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      vld_q   <= vld_d;
    end
  end
  // The response of vector k is registered at the end of its cycle and folded one
  // cycle later, so the first RUN cycle has nothing to fold and DRAIN folds the last.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        lfsr_d  = SEED_EFF;
        misr_d  = '0;
        cnt_d   = '0;
        resp_d  = 1'b0;
        vld_d   = 1'b0;
      end
      RUN: begin
        lfsr_d  = {lfsr_q[12:0], fb};
        cnt_d   = cnt_q + 16'd1;
        resp_d  = cut_resp;
        vld_d   = 1'b1;
        misr_d  = vld_q ? fold : misr_q;
        state_d = (cnt_q + 16'd1 == PC) ? DRAIN : RUN;
      end
      DRAIN: begin
        misr_d  = fold;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef S1488_BIST_HOLD_CLR_EN
  assign pat_vec = {1'b1, lfsr_q[12:0]};
`else
  assign pat_vec = lfsr_q;
`endif
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = state_q == DONE;
  assign signature = misr_q;
  assign pass      = done && (misr_q == golden);
endmodule

// File: tb/tb_s1488_bist_ctrl.sv
// tb_s1488_bist_ctrl: directed self-checking bench for s1488_bist_ctrl with PAT_COUNT=4
module tb_s1488_bist_ctrl;
`ifdef S1488_BIST_HOLD_CLR_EN
  localparam logic [13:0] HM = 14'h2000;
`else
  localparam logic [13:0] HM = 14'h0000;
`endif
  logic CK = 1'b0, CLR, start, cut_resp, busy, done, pass;
  logic [15:0] golden, signature;
  logic [13:0] pat_vec;
  int checks = 0, failures = 0;
  s1488_bist_ctrl #(.PAT_COUNT(4), .SEED(14'h0001)) dut (
    .CK(CK), .CLR(CLR), .start(start), .golden(golden), .cut_resp(cut_resp),
    .pat_vec(pat_vec), .busy(busy), .done(done), .signature(signature), .pass(pass)
  );
  always #5 CK = ~CK;
  task automatic tick;
    @(posedge CK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    CLR = 1'b0; start = 1'b0; golden = 16'h0; cut_resp = 1'b0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_pat", pat_vec, 14'h0001 | HM);
    CLR = 1'b1;
    tick;
    chk("idle_pat", pat_vec, 14'h0001 | HM);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_sig", signature, 16'h0000);
    chk("idle_pass", pass, 0);
    start = 1'b1;
    tick;
    start = 1'b0; cut_resp = 1'b1;
    chk("run1_busy", busy, 1);
    chk("run1_pat", pat_vec, 14'h0001 | HM);
    tick;
    cut_resp = 1'b0; start = 1'b1;
    chk("run2_pat", pat_vec, 14'h0002 | HM);
    tick;
    start = 1'b0;
    chk("run3_pat", pat_vec, 14'h0005 | HM);
    chk("run3_busy", busy, 1);
    tick;
    chk("run4_pat", pat_vec, 14'h000A | HM);
    tick;
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    tick;
    chk("done_done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_sig", signature, 16'h0008);
    chk("done_pass_bad_golden", pass, 0);
    golden = 16'h0008;
    #1;
    chk("done_pass_good_golden", pass, 1);
    tick;
    chk("done_hold", done, 1);
    start = 1'b1;
    tick;
    cut_resp = 1'b1;
    chk("rerun_done", done, 0);
    chk("rerun_busy", busy, 1);
    chk("rerun_pat", pat_vec, 14'h0001 | HM);
    chk("rerun_sig_clr", signature, 16'h0000);
    tick;
    cut_resp = 1'b0;
    tick; tick; tick;
    chk("rerun_drain_busy", busy, 1);
    tick;
    chk("rerun2_done", done, 1);
    chk("rerun2_sig", signature, 16'h0008);
    chk("rerun2_pass", pass, 1);
    tick;
    chk("b2b_done_one_cycle", done, 0);
    chk("b2b_pat", pat_vec, 14'h0001 | HM);
    chk("b2b_sig", signature, 16'h0000);
    chk("b2b_pass", pass, 0);
    start = 1'b0; cut_resp = 1'b1;
    tick;
    cut_resp = 1'b0;
    tick;
    chk("mid_sig", signature, 16'h0001);
    chk("mid_busy", busy, 1);
    #1 CLR = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_sig", signature, 16'h0000);
    chk("async_pat", pat_vec, 14'h0001 | HM);
    #1 CLR = 1'b1;
    tick; tick;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
